// File: rtl/bounce_gen.sv
// bounce_gen: contact-bounce emulator; each level change yields 2k+1 sw_out edges, then a stable hold.
// Define BOUNCE_GEN_RANDOM_EN to draw k and the gap lengths from a 16-bit LFSR (default: worst case k, MIN_GAP).
module bounce_gen #(
    parameter int unsigned BW      = 3,
    parameter int unsigned GW      = 4,
    parameter int unsigned MIN_GAP = 2,
    parameter int unsigned HOLD    = 16,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic clk,
    input  logic reset,
    input  logic level_in,
    output logic sw_out,
    output logic busy,
    output logic done_tick
);
    localparam int unsigned GAP_MAX = MIN_GAP + (1 << GW) - 1;
    localparam int unsigned CNT_MAX = (GAP_MAX > HOLD) ? GAP_MAX : HOLD;
    // The counter holds (length - 1), so CNT_MAX itself never needs to be represented.
    localparam int unsigned CW      = $clog2(CNT_MAX);
    localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD - 1);

    if (SEED == 16'h0 || MIN_GAP < 1 || HOLD < 1) begin : g_bad_param
        $error("bounce_gen: SEED must be nonzero, MIN_GAP and HOLD must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_e;
    typedef enum logic {PH_ON, PH_OFF} phase_e;

    state_e        state_q, state_d;
    phase_e        phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] k_q, k_d;
    logic          tgt_q, tgt_d;
    logic          lvl_q, lvl_d;
    logic          sw_out_q, sw_out_d;
    logic          busy_q, busy_d;
    logic          done_tick_q, done_tick_d;

    logic [BW-1:0] k_load;
    logic [CW-1:0] gap_m1;

`ifdef BOUNCE_GEN_RANDOM_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        k_load = lfsr_q[BW-1:0];
        gap_m1 = CW'(MIN_GAP - 1) + CW'(lfsr_q[GW-1:0]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) lfsr_q <= SEED;
        else        lfsr_q <= lfsr_d;
    end
`else
    always_comb begin
        k_load = '1;
        gap_m1 = CW'(MIN_GAP - 1);
    end
`endif

    // The final ON phase is folded into the SETTLE window, so k counts remaining OFF glitches.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        k_d      = k_q;
        tgt_d    = tgt_q;
        lvl_d    = lvl_q;
        sw_out_d = sw_out_q;
        case (state_q)
            IDLE: begin
                sw_out_d = lvl_q;
                if (level_in != lvl_q) begin
                    tgt_d    = level_in;
                    sw_out_d = level_in;
                    k_d      = k_load;
                    phase_d  = PH_ON;
                    if (k_load == '0) begin
                        state_d = SETTLE;
                        cnt_d   = HOLD_M1;
                    end else begin
                        state_d = BOUNCE;
                        cnt_d   = gap_m1;
                    end
                end
            end
            BOUNCE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (phase_q == PH_ON) begin
                    sw_out_d = ~tgt_q;
                    phase_d  = PH_OFF;
                    cnt_d    = gap_m1;
                end else begin
                    sw_out_d = tgt_q;
                    phase_d  = PH_ON;
                    k_d      = k_q - 1'b1;
                    if (k_q == BW'(1)) begin
                        state_d = SETTLE;
                        cnt_d   = HOLD_M1;
                    end else begin
                        cnt_d = gap_m1;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = IDLE;
                    lvl_d   = tgt_q;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d      = (state_d != IDLE);
        done_tick_d = (state_d == SETTLE) && (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            phase_q     <= PH_ON;
            cnt_q       <= '0;
            k_q         <= '0;
            tgt_q       <= 1'b0;
            lvl_q       <= 1'b0;
            sw_out_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_tick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            tgt_q       <= tgt_d;
            lvl_q       <= lvl_d;
            sw_out_q    <= sw_out_d;
            busy_q      <= busy_d;
            done_tick_q <= done_tick_d;
        end
    end

    assign sw_out    = sw_out_q;
    assign busy      = busy_q;
    assign done_tick = done_tick_q;

endmodule

// File: tb/tb_bounce_gen.sv
// Testbench for bounce_gen: queue-based event model checked every cycle, plus directed literal expectations.
module tb_bounce_gen;
    localparam int          BW      = 3;
    localparam int          GW      = 4;
    localparam int          MIN_GAP = 2;
    localparam int          HOLD    = 16;
    localparam logic [15:0] SEED    = 16'hACE1;

    logic clk      = 1'b0;
    logic reset    = 1'b0;
    logic level_in = 1'b0;
    logic sw_out, busy, done_tick;

    int n_checks = 0;
    int n_fail   = 0;

    bounce_gen #(.BW(BW), .GW(GW), .MIN_GAP(MIN_GAP), .HOLD(HOLD), .SEED(SEED)) dut (
        .clk(clk), .reset(reset), .level_in(level_in),
        .sw_out(sw_out), .busy(busy), .done_tick(done_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    function automatic int gap_of(input logic [15:0] l);
`ifdef BOUNCE_GEN_RANDOM_EN
        return MIN_GAP + int'(l[GW-1:0]);
`else
        return MIN_GAP + 0 * int'(l[0]);
`endif
    endfunction

    // Model: an event is a precomputed list of per-cycle (sw, done) values; busy while the list is non-empty.
    logic [15:0] m_lfsr = SEED;
    logic        m_lvl  = 1'b0;
    logic        m_tgt  = 1'b0;
    logic        q_sw[$];
    logic        q_done[$];

    task automatic build_event(input logic tgt, input logic [15:0] l0);
        logic [15:0] l;
        int          k;
        int          g;
        l     = l0;
        m_tgt = tgt;
`ifdef BOUNCE_GEN_RANDOM_EN
        k = int'(l0[BW-1:0]);
`else
        k = (1 << BW) - 1;
`endif
        for (int i = 0; i < 2 * k; i++) begin
            g = gap_of(l);
            repeat (g) begin
                q_sw.push_back((i % 2 == 0) ? tgt : ~tgt);
                q_done.push_back(1'b0);
            end
            repeat (g) l = lfsr_step(l);
        end
        repeat (HOLD - 1) begin
            q_sw.push_back(tgt);
            q_done.push_back(1'b0);
        end
        q_sw.push_back(tgt);
        q_done.push_back(1'b1);
    endtask

    always @(posedge clk) begin
        if (!reset) begin
            q_sw.delete();
            q_done.delete();
            m_lvl  = 1'b0;
            m_lfsr = SEED;
        end else begin
            if (q_sw.size() == 0) begin
                if (level_in != m_lvl) build_event(level_in, m_lfsr);
            end else begin
                void'(q_sw.pop_front());
                void'(q_done.pop_front());
                if (q_sw.size() == 0) m_lvl = m_tgt;
            end
            m_lfsr = lfsr_step(m_lfsr);
        end
    end

    always @(posedge clk) begin
        logic [2:0] exp_v;
        #3;
        if (reset) begin
            if (q_sw.size() != 0) exp_v = {q_sw[0], 1'b1, q_done[0]};
            else                  exp_v = {m_lvl, 1'b0, 1'b0};
            check("model {sw,busy,done}", {29'd0, sw_out, busy, done_tick}, {29'd0, exp_v});
        end
    end

    // Trace capture: called at a negedge; index i is the cycle after the i-th following clock edge.
    logic tr_sw[0:511];
    logic tr_busy[0:511];
    logic tr_done[0:511];
    logic saved_sw[0:511];

    task automatic capture(input logic lv, input int n, input int c1, input logic v1,
                           input int c2, input logic v2);
        tr_sw[0]   = sw_out;
        tr_busy[0] = busy;
        tr_done[0] = done_tick;
        level_in   = lv;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            tr_sw[i]   = sw_out;
            tr_busy[i] = busy;
            tr_done[i] = done_tick;
            if (i == c1) level_in = v1;
            if (i == c2) level_in = v2;
        end
    endtask

    // Worst-case event shape: 2-cycle phases through cycle 28, stable from 29, done at 44, idle from 45.
    task automatic check_off(input logic tgt, input int off, input int from, input int to, input string name);
        int         r;
        logic [2:0] e;
        for (int i = from; i <= to; i++) begin
            r = i - off;
            e = {(r <= 28 && ((r - 1) / 2) % 2 == 1) ? ~tgt : tgt, r <= 44, r == 44};
            check($sformatf("%s cycle %0d", name, i), {29'd0, tr_sw[i], tr_busy[i], tr_done[i]}, {29'd0, e});
        end
    endtask

    task automatic count_edges(input int n, output int rise, output int fall);
        rise = 0;
        fall = 0;
        for (int i = 1; i <= n; i++) begin
            if (!tr_sw[i-1] && tr_sw[i]) rise++;
            if (tr_sw[i-1] && !tr_sw[i]) fall++;
        end
    endtask

    task automatic check_runs(input int n, input string name);
        int len;
        int runs[$];
        len = 0;
        for (int i = 1; i <= n && tr_busy[i]; i++) begin
            if (i > 1 && tr_sw[i] != tr_sw[i-1]) begin
                runs.push_back(len);
                len = 0;
            end
            len++;
        end
        runs.push_back(len);
        for (int j = 0; j < runs.size() - 1; j++)
            check_range($sformatf("%s phase %0d", name, j), runs[j], MIN_GAP, MIN_GAP + (1 << GW) - 1);
        check_range($sformatf("%s hold", name), runs[runs.size()-1], HOLD, HOLD);
    endtask

    initial begin
        int rise, fall, nmis;
        repeat (3) @(negedge clk);
        check("reset sw_out", {31'd0, sw_out}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done_tick", {31'd0, done_tick}, 32'd0);
        check("lfsr step1", {16'd0, lfsr_step(SEED)}, 32'h5670);
        check("lfsr step3", {16'd0, lfsr_step(lfsr_step(lfsr_step(SEED)))}, 32'h559C);
`ifdef BOUNCE_GEN_RANDOM_EN
        for (int run = 0; run < 2; run++) begin
            reset    = 1'b0;
            level_in = 1'b0;
            repeat (2) @(negedge clk);
            reset = 1'b1;
            capture(1'b1, 300, 0, 1'b0, 0, 1'b0);
            // k = SEED[2:0] = 1, first gap 2+1 = 3, second gap 2+0xC = 14.
            check("rnd on phase end", {30'd0, tr_sw[3], tr_sw[4]}, 32'h2);
            check("rnd off phase end", {30'd0, tr_sw[17], tr_sw[18]}, 32'h1);
            check("rnd done cycle 33", {30'd0, tr_done[33], tr_busy[34]}, 32'h2);
            count_edges(300, rise, fall);
            check("rnd k from seed", fall, 32'd1);
            check_runs(300, "rnd rise");
            if (run == 0) begin
                for (int i = 0; i <= 300; i++) saved_sw[i] = tr_sw[i];
            end else begin
                nmis = 0;
                for (int i = 0; i <= 300; i++) if (saved_sw[i] !== tr_sw[i]) nmis++;
                check("rnd repeatable trace", nmis, 32'd0);
            end
            capture(1'b0, 300, 0, 1'b0, 0, 1'b0);
            check_runs(300, "rnd fall");
            check("rnd final low", {31'd0, tr_sw[300]}, 32'd0);
        end
`else
        reset = 1'b1;
        capture(1'b1, 60, 0, 1'b0, 0, 1'b0);
        check_off(1'b1, 0, 1, 60, "rise");
        count_edges(60, rise, fall);
        check("rise edges up", rise, 32'd8);
        check("rise edges down", fall, 32'd7);

        capture(1'b0, 60, 0, 1'b0, 0, 1'b0);
        check_off(1'b0, 0, 1, 60, "fall");
        count_edges(60, rise, fall);
        check("fall edges up", rise, 32'd7);
        check("fall edges down", fall, 32'd8);

        capture(1'b1, 100, 35, 1'b0, 0, 1'b0);
        check_off(1'b1, 0, 1, 45, "settle chg first");
        check_off(1'b0, 45, 46, 100, "settle chg second");

        capture(1'b1, 70, 5, 1'b0, 8, 1'b1);
        check_off(1'b1, 0, 1, 70, "pulse in bounce");

        capture(1'b0, 60, 0, 1'b0, 0, 1'b0);
        check_off(1'b0, 0, 1, 60, "fall again");

        capture(1'b1, 10, 0, 1'b0, 0, 1'b0);
        check_off(1'b1, 0, 1, 10, "pre reset");
        #2 reset = 1'b0;
        #1;
        check("async reset {sw,busy,done}", {29'd0, sw_out, busy, done_tick}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        capture(1'b1, 60, 0, 1'b0, 0, 1'b0);
        check_off(1'b1, 0, 1, 60, "after reset");
        count_edges(60, rise, fall);
        check("after reset edges up", rise, 32'd8);
        check("after reset edges down", fall, 32'd7);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
